// File: rtl/channel_rr_scheduler.sv
// channel_rr_scheduler: round-robin/burst arbiter feeding a single-entry valid/ready output buffer.
// Define CHSCHED_STALL_CNT_EN to add the saturating stall_cycles counter output.
module channel_rr_scheduler #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [NUM_CHANNELS-1:0]         req_valid,
    input  logic [DATA_WIDTH-1:0]           req_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]         req_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_CHANNELS)-1:0] out_channel,
    output logic                            burst_active,
`ifdef CHSCHED_STALL_CNT_EN
    output logic [15:0]                     stall_cycles,
`endif
    input  logic                            out_ready
);
    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         last_grant_q, last_grant_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]         out_channel_q, out_channel_d;
    logic                  can_load;
    logic                  grant_vld;
    logic [CW-1:0]         grant_idx;

    assign can_load = !out_valid_q || out_ready;

    // Scan from farthest to nearest so the channel right after last_grant wins.
    always_comb begin
        int c;
        c = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (enable && can_load) begin
            if (state_q == BURST && req_valid[last_grant_q] && burst_cnt_q < BW'(MAX_BURST)) begin
                grant_vld = 1'b1;
                grant_idx = last_grant_q;
            end else begin
                for (int i = NUM_CHANNELS; i >= 1; i--) begin
                    c = (int'(last_grant_q) + i) % NUM_CHANNELS;
                    if (req_valid[CW'(c)]) begin
                        grant_vld = 1'b1;
                        grant_idx = CW'(c);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    // A re-grant to the owner after a forced rotation with no rival starts a fresh burst.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if (grant_vld) begin
            state_d      = BURST;
            last_grant_d = grant_idx;
            burst_cnt_d  = (state_q == BURST && grant_idx == last_grant_q && burst_cnt_q < BW'(MAX_BURST))
                         ? burst_cnt_q + 1'b1 : BW'(1);
        end else if (state_q == BURST && (!enable || can_load)) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
        end
    end

    always_comb begin
        out_valid_d   = grant_vld ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_data_d    = grant_vld ? req_data[grant_idx] : out_data_q;
        out_channel_d = grant_vld ? grant_idx : out_channel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= CW'(NUM_CHANNELS - 1);
            burst_cnt_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            burst_cnt_q   <= burst_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_channel  = out_channel_q;
    assign burst_active = (state_q == BURST);

`ifdef CHSCHED_STALL_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = (out_valid_q && !out_ready && stall_cycles_q != 16'hFFFF)
                       ? stall_cycles_q + 16'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_channel_rr_scheduler.sv
// tb_channel_rr_scheduler: scoreboard bench; expected beats are queued as stimulus is driven
// and popped whenever the output handshake completes.
module tb_channel_rr_scheduler;
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] req_valid;
    logic [7:0] req_data [4];
    logic [3:0] req_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_channel;
    logic       out_ready;
    logic       burst_active;
`ifdef CHSCHED_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] sb_q [$];

    channel_rr_scheduler #(.NUM_CHANNELS(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_channel  (out_channel),
        .burst_active (burst_active),
`ifdef CHSCHED_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] d);
        sb_q.push_back({ch, d});
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        for (int i = 0; i < 3; i++) tick();
        check("sb_drained", 32'(sb_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected_beat", {22'd0, out_channel, out_data}, 32'h3FF);
            else check("sb_beat", {22'd0, out_channel, out_data}, {22'd0, sb_q.pop_front()});
        end
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_channel", 32'(out_channel), 0);
        check("rst_burst_active", 32'(burst_active), 0);
        check("rst_req_ready", 32'(req_ready), 0);
`ifdef CHSCHED_STALL_CNT_EN
        check("rst_stall", 32'(stall_cycles), 0);
`endif
        tick();
        rst_n = 1'b1;

        // single request on channel 2
        req_valid   = 4'b0100;
        req_data[2] = 8'hA5;
        push(2'd2, 8'hA5);
        #1 check("single_req_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        check("single_out_valid", 32'(out_valid), 1);
        check("single_out_data", 32'(out_data), 32'hA5);
        check("single_out_channel", 32'(out_channel), 2);
        drain();

        // all channels requesting: bursts of four in channel order
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) req_data[i] = 8'(i);
        for (int i = 0; i < 20; i++) push(2'((i / 4) % 4), 8'((i / 4) % 4));
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rr_burst_active", 32'(burst_active), 1);
        end
        drain();

        // channel 1 streams three beats, then hands over to channel 3
        do_reset();
        req_valid   = 4'b0010;
        req_data[1] = 8'h11;
        req_data[3] = 8'h33;
        for (int i = 0; i < 3; i++) push(2'd1, 8'h11);
        push(2'd3, 8'h33);
        for (int i = 0; i < 3; i++) tick();
        req_valid = 4'b1000;
        #1 check("switch_req_ready", 32'(req_ready), 32'b1000);
        check("switch_burst_active", 32'(burst_active), 1);
        tick();
        check("switch_out_channel", 32'(out_channel), 3);
        drain();

        // backpressure for five cycles, then same-cycle refill
        do_reset();
        out_ready   = 1'b0;
        req_valid   = 4'b0001;
        req_data[0] = 8'h40;
        push(2'd0, 8'h40);
        push(2'd0, 8'h41);
        tick();
        req_data[0] = 8'h41;
        for (int i = 0; i < 5; i++) begin
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_out_data", 32'(out_data), 32'h40);
            tick();
        end
`ifdef CHSCHED_STALL_CNT_EN
        check("bp_stall_cycles", 32'(stall_cycles), 5);
`endif
        out_ready = 1'b1;
        #1 check("bp_refill_req_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check("bp_refill_out_valid", 32'(out_valid), 1);
        check("bp_refill_out_data", 32'(out_data), 32'h41);
        drain();

        // enable dropped mid-burst
        do_reset();
        req_valid   = 4'b0011;
        req_data[0] = 8'h50;
        req_data[1] = 8'h51;
        push(2'd0, 8'h50);
        push(2'd0, 8'h50);
        push(2'd1, 8'h51);
        tick();
        tick();
        enable = 1'b0;
        #1 check("en_off_req_ready", 32'(req_ready), 0);
        check("en_off_out_valid", 32'(out_valid), 1);
        tick();
        check("en_off_drained", 32'(out_valid), 0);
        check("en_off_idle", 32'(burst_active), 0);
        enable = 1'b1;
        #1 check("en_on_scan_next", 32'(req_ready), 32'b0010);
        tick();
        drain();

        // asynchronous reset while a beat is buffered mid-burst
        do_reset();
        out_ready   = 1'b0;
        req_valid   = 4'b0001;
        req_data[0] = 8'h60;
        tick();
        check("arst_pre_out_valid", 32'(out_valid), 1);
        check("arst_pre_burst", 32'(burst_active), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_burst_active", 32'(burst_active), 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) req_data[i] = 8'(8'h70 + i);
        push(2'd0, 8'h70);
        #1 check("arst_first_priority", 32'(req_ready), 32'b0001);
        tick();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end
endmodule
